out_reg_fifo: RTL and testbench

Parametrised successor to the SAP-1 output/B register. Bus writes (`reg_load`) are captured into a DEPTH-entry FIFO, so a slow consumer such as a display driver or serial sink can drain values with a valid/ready handshake. Bus writes never stall the CPU.

The most recently loaded value is also held in a shadow register. That value can be driven back onto the shared W-bus through a tri-state output when `reg_enable` is high, preserving the classic register read-back behaviour. A sticky overflow flag records writes lost while the FIFO was full.

---
 rtl/out_reg_fifo.sv | 93 +++++++++
 tb/tb_out_reg_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/out_reg_fifo.sv
// Output register with a DEPTH-entry FIFO behind it, plus a shadow copy of the last
// bus write that can be read back onto the shared W-bus through a tri-state driver.
module out_reg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             reg_load,
    input  logic             reg_enable,
    output tri   [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [WIDTH-1:0]            shadow_q, shadow_d;
    logic                        ovf_q, ovf_d;
    logic                        push, pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign overflow  = ovf_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // when the consumer is draining.
    assign pop  = out_valid && out_ready;
    assign push = reg_load && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        if (reg_load)
            shadow_d = data_in;
        // A dropped write beats a clear arriving in the same cycle.
        if (reg_load && !push)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never cleared; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (reset_n && push)
            mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out = reg_enable ? shadow_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_out_reg_fifo.sv
// Directed bench for out_reg_fifo: a queue-based model checked every cycle, plus
// hand-computed checkpoints along the test plan.
module tb_out_reg_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] data_in;
    logic             reg_load;
    logic             reg_enable;
    wire  [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             clr_ovf;

    out_reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .reg_load   (reg_load),
        .reg_enable (reg_enable),
        .data_out   (data_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue, plus shadow value and sticky flag.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_shadow;
    logic             m_ovf;
    bit               chk_en = 0;
    int               n_pop  = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_shadow = '0;
            m_ovf    = 1'b0;
            chk_en   = 1;
        end else begin
            bit do_pop, do_push;
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = reg_load && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) begin
                void'(mq.pop_front());
                n_pop++;
            end
            if (do_push) mq.push_back(data_in);
            if (reg_load) m_shadow = data_in;
            if (reg_load && !do_push) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (reg_enable) chk("data_out", 32'(data_out), 32'(m_shadow));
        end
    end

    // Inputs change 1 time unit after the falling edge; one rising edge per call.
    task automatic step(input logic ld, input logic [WIDTH-1:0] din, input logic rdy,
                        input logic en, input logic clr, input logic rn);
        reg_load   = ld;
        data_in    = din;
        out_ready  = rdy;
        reg_enable = en;
        clr_ovf    = clr;
        reset_n    = rn;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reg_load = 0; data_in = 0; out_ready = 0; reg_enable = 0; clr_ovf = 0; reset_n = 0;
        #1;

        // Reset with a load asserted: reset wins.
        step(1, 8'hFF, 0, 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0, 0);
        chk("lit_rst_count", 32'(count), 0);
        chk("lit_rst_empty", 32'(empty), 1);
        chk("lit_rst_ovf", 32'(overflow), 0);
        chk("lit_rst_valid", 32'(out_valid), 0);
        reg_enable = 1; #1;
        chk("lit_rst_dout", 32'(data_out), 32'h00);
        reg_enable = 0; #1;

        // Order and latency.
        step(1, 8'h11, 0, 0, 0, 1);
        chk("lit_lat_valid", 32'(out_valid), 1);
        chk("lit_lat_head", 32'(out_data), 32'h11);
        step(1, 8'h22, 0, 0, 0, 1);
        step(1, 8'h33, 0, 0, 0, 1);
        chk("lit_cnt3", 32'(count), 3);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("lit_pop1_head", 32'(out_data), 32'h22);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("lit_pop2_head", 32'(out_data), 32'h33);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("lit_drained", 32'(empty), 1);

        // Full and overflow.
        for (int i = 0; i < 5; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0, 1);
        chk("lit_full", 32'(full), 1);
        chk("lit_full_cnt", 32'(count), 4);
        chk("lit_ovf", 32'(overflow), 1);
        chk("lit_full_head", 32'(out_data), 32'hA0);
        reg_enable = 1; #1;
        chk("lit_shadow_a4", 32'(data_out), 32'hA4);
        step(0, 8'h00, 0, 1, 1, 1);
        chk("lit_ovf_clr", 32'(overflow), 0);

        // Full with simultaneous push and pop; read-back shows old value that cycle.
        reg_load = 1; data_in = 8'hB0; out_ready = 1; #1;
        chk("lit_dout_old", 32'(data_out), 32'hA4);
        step(1, 8'hB0, 1, 1, 0, 1);
        chk("lit_pp_cnt", 32'(count), 4);
        chk("lit_pp_ovf", 32'(overflow), 0);
        chk("lit_pp_head", 32'(out_data), 32'hA1);
        chk("lit_dout_new", 32'(data_out), 32'hB0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, 1);
        chk("lit_tail_b0", 32'(out_data), 32'hB0);
        step(0, 8'h00, 1, 0, 0, 1);
        chk("lit_pp_empty", 32'(empty), 1);

        // Wrap-around stream with random stalls on the producer side.
        n_pop = 0;
        for (int v = 0; v < 20; v++) begin
            while ($urandom_range(0, 2) == 0) step(0, 8'h00, 1, 0, 0, 1);
            step(1, 8'h40 + 8'(v), 1, 0, 0, 1);
        end
        step(0, 8'h00, 1, 0, 0, 1);
        chk("lit_wrap_pops", 32'(n_pop), 20);
        chk("lit_wrap_empty", 32'(empty), 1);

        // Push with out_ready while empty: no pop.
        step(1, 8'h5A, 1, 0, 0, 1);
        chk("lit_ep_cnt", 32'(count), 1);
        chk("lit_ep_head", 32'(out_data), 32'h5A);
        step(1, 8'h5B, 0, 0, 0, 1);
        step(1, 8'h5C, 0, 0, 0, 1);
        chk("lit_mid_cnt3", 32'(count), 3);
        step(0, 8'h00, 1, 0, 1, 0);
        chk("lit_mid_rst_cnt", 32'(count), 0);
        chk("lit_mid_rst_valid", 32'(out_valid), 0);
        step(0, 8'h00, 1, 1, 0, 1);
        chk("lit_post_empty", 32'(empty), 1);
        chk("lit_post_dout", 32'(data_out), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
